dmem_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as the responder on the core's data-memory port (port B).
- Uses the same addr/we/di/do conventions as BRAM port B: byte write enables with data already lane-aligned by the store path, and synchronous reads with 1-cycle latency.
- Top-level address decode asserts sel. Bytes written by software enter a TX FIFO and are serialized 8N1 on tx.

---
 rtl/dmem_uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_tx.sv
// rtl/dmem_uart_tx.sv - memory-mapped 8N1 UART transmitter on the data-memory port B
module dmem_uart_tx #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic [31:0] di,
    output logic [31:0] dout,
    output logic        tx,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   bauddiv;
    logic          en;
    logic          irqen;
    logic          ovf;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   clk_cnt;
    logic [15:0]   div_lat;

    logic [1:0]    reg_sel;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud_lo;
    logic          wr_baud_hi;
    logic          wr_ctrl;
    logic          full;
    logic          empty;
    logic          busy;
    logic          pop;
    logic          push;
    logic          bit_done;
    logic [31:0]   cnt_wide;
    logic [3:0]    cnt_sat;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign reg_sel    = addr[3:2];
    assign wr_txdata  = sel && we[0] && (reg_sel == 2'd0);
    assign wr_status  = sel && we[0] && (reg_sel == 2'd1);
    assign wr_baud_lo = sel && we[0] && (reg_sel == 2'd2);
    assign wr_baud_hi = sel && we[1] && (reg_sel == 2'd2);
    assign wr_ctrl    = sel && we[0] && (reg_sel == 2'd3);

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign busy   = (state != S_IDLE);
    assign pop    = (state == S_IDLE) && en && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push   = wr_txdata && (!full || pop);
    assign bit_done = (clk_cnt == (div_lat - 16'd1));

    assign irq = irqen && empty && !busy;

    assign cnt_wide = 32'(count);
    assign cnt_sat  = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            2'd0: rd_val = 32'd0;
            2'd1: rd_val = {20'd0, cnt_sat, 4'd0, ovf, busy, empty, full};
            2'd2: rd_val = {16'd0, bauddiv};
            2'd3: rd_val = {30'd0, irqen, en};
            default: rd_val = 32'd0;
        endcase
    end

    assign unused_bits = ^{addr[31:4], addr[1:0], we[3:2], di[31:16], cnt_wide[31:4]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= di[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bauddiv <= 16'(CLKS_PER_BIT);
            en      <= 1'b1;
            irqen   <= 1'b0;
            ovf     <= 1'b0;
            dout    <= 32'd0;
        end else begin
            if (sel) begin
                dout <= rd_val;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (wr_txdata && !push) begin
                ovf <= 1'b1;
            end else if (wr_status && di[3]) begin
                ovf <= 1'b0;
            end
            if (wr_baud_lo) begin
                bauddiv[7:0] <= di[7:0];
            end
            if (wr_baud_hi) begin
                bauddiv[15:8] <= di[15:8];
            end
            if (wr_ctrl) begin
                en    <= di[0];
                irqen <= di[1];
            end
        end
    end

    // The divisor is latched at frame start so BAUDDIV writes never stretch a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= 8'd0;
            bit_idx <= 3'd0;
            clk_cnt <= 16'd0;
            div_lat <= 16'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        div_lat <= (bauddiv == 16'd0) ? 16'd1 : bauddiv;
                        clk_cnt <= 16'd0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        state   <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// tb/tb_dmem_uart_tx.sv - testbench for dmem_uart_tx
module tb_dmem_uart_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] di;
    logic [31:0] dout;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    byte unsigned model_q[$];
    bit           model_ovf;
    bit           model_en;
    bit           model_irqen;
    int           model_div;

    always #5 clk = ~clk;

    dmem_uart_tx #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(868)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .di    (di),
        .dout  (dout),
        .tx    (tx),
        .irq   (irq)
    );

    function automatic logic [31:0] status_word(int cnt, bit ovf, bit busy);
        int c;
        c = (cnt > 15) ? 15 : cnt;
        return {20'd0, c[3:0], 4'd0, ovf, busy, (cnt == 0), (cnt == DEPTH)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        sel = 1'b1; addr = a; we = w; di = d;
        step();
        sel = 1'b0; we = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; addr = a; we = 4'd0;
        step();
        sel = 1'b0;
        d = dout;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf   = 1'b0;
        model_en    = 1'b1;
        model_irqen = 1'b0;
        model_div   = 868;
    endtask

    task automatic model_push(input byte unsigned b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    // Expects tx idle for exp_lat samples, then one full frame of the model's head byte.
    task automatic check_frame(input int exp_lat);
        byte unsigned b;
        int d;
        int bit_n;
        logic e;
        sel = 1'b1; addr = 32'h4; we = 4'd0;
        for (int i = 0; i < exp_lat; i++) begin
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL frame_gap: tx=%b expected 1", tx);
            end
            step();
        end
        checks++;
        if (tx !== 1'b0 || model_q.size() == 0) begin
            errors++;
            $display("FAIL frame_start: tx=%b expected 0 (model depth %0d)", tx, model_q.size());
            sel = 1'b0;
            return;
        end
        b = model_q.pop_front();
        d = (model_div == 0) ? 1 : model_div;
        for (int k = 0; k < 10 * d; k++) begin
            bit_n = k / d;
            if (bit_n == 0) e = 1'b0;
            else if (bit_n == 9) e = 1'b1;
            else e = b[bit_n-1];
            checks++;
            if (tx !== e) begin
                errors++;
                $display("FAIL frame_tx byte %h cycle %0d: tx=%b expected %b", b, k, tx, e);
            end
            if (k > 0) begin
                checks++;
                if (dout !== status_word(model_q.size(), model_ovf, 1'b1)) begin
                    errors++;
                    $display("FAIL frame_status cycle %0d: got %h expected %h", k, dout,
                             status_word(model_q.size(), model_ovf, 1'b1));
                end
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL frame_irq cycle %0d: irq=%b expected 0", k, irq);
            end
            step();
        end
        sel = 1'b0;
        checks++;
        if (irq !== (model_irqen && model_q.size() == 0)) begin
            errors++;
            $display("FAIL post_frame_irq: irq=%b expected %b", irq, model_irqen && model_q.size() == 0);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_n = 1'b0; sel = 1'b0; addr = 32'd0; we = 4'd0; di = 32'd0;
        repeat (3) step();
        checks++;
        if (dout !== 32'd0) begin errors++; $display("FAIL reset_do: got %h expected 0", dout); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        step();
        model_reset();
        bus_read(32'h4, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", r); end
        bus_read(32'h8, r);
        checks++;
        if (r !== 32'd868) begin errors++; $display("FAIL reset_bauddiv: got %h expected %h", r, 32'd868); end
        bus_read(32'hC, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000001", r); end
    endtask

    task automatic test_registers();
        logic [31:0] r;
        logic [31:0] v;
        v = $urandom;
        bus_write(32'h8, 4'b0001, v);
        model_div = (model_div & 32'hFF00) | (v & 32'hFF);
        bus_read(32'h8, r);
        checks++;
        if (r !== model_div) begin errors++; $display("FAIL baud_lo_lane: got %h expected %h", r, model_div); end
        v = $urandom;
        bus_write(32'h8, 4'b0010, v);
        model_div = (model_div & 32'h00FF) | (v & 32'hFF00);
        bus_read(32'h8, r);
        checks++;
        if (r !== model_div) begin errors++; $display("FAIL baud_hi_lane: got %h expected %h", r, model_div); end
        bus_write(32'h8, 4'b1100, $urandom);
        sel = 1'b0; addr = 32'h8; we = 4'hF; di = $urandom;
        step();
        we = 4'd0;
        bus_read(32'h8, r);
        checks++;
        if (r !== model_div) begin errors++; $display("FAIL baud_ignored_writes: got %h expected %h", r, model_div); end
        bus_read(32'h0, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h expected 0", r); end
    endtask

    task automatic test_single_frame();
        byte unsigned b;
        bus_write(32'h8, 4'b0011, 32'd4);
        model_div = 4;
        bus_write(32'h0, 4'b0001, 32'hA5);
        model_push(8'hA5);
        check_frame(1);
        for (int n = 0; n < 3; n++) begin
            model_div = (n == 0) ? 0 : $urandom_range(1, 5);
            bus_write(32'h8, 4'b0011, model_div);
            b = $urandom;
            bus_write(32'h0, 4'b0001, {24'd0, b});
            model_push(b);
            check_frame(1);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus_write(32'hC, 4'b0001, 32'd0);
        model_en = 1'b0; model_irqen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_write(32'h0, 4'b0001, i);
            model_push(8'(i));
        end
        bus_read(32'h4, r);
        checks++;
        if (r !== status_word(model_q.size(), model_ovf, 1'b0)) begin
            errors++; $display("FAIL ovf_status: got %h expected %h", r, status_word(model_q.size(), model_ovf, 1'b0));
        end
        bus_write(32'h4, 4'b0001, 32'h0);
        bus_read(32'h4, r);
        checks++;
        if (r !== status_word(model_q.size(), model_ovf, 1'b0)) begin
            errors++; $display("FAIL ovf_kept: got %h expected %h", r, status_word(model_q.size(), model_ovf, 1'b0));
        end
        bus_write(32'h4, 4'b0001, 32'h8);
        model_ovf = 1'b0;
        bus_read(32'h4, r);
        checks++;
        if (r !== status_word(model_q.size(), model_ovf, 1'b0)) begin
            errors++; $display("FAIL ovf_clear: got %h expected %h", r, status_word(model_q.size(), model_ovf, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int idle_bad;
        bus_write(32'h8, 4'b0011, 32'd2);
        model_div = 2;
        bus_write(32'hC, 4'b0001, 32'd3);
        model_en = 1'b1; model_irqen = 1'b1;
        for (int i = 0; i < DEPTH; i++) check_frame(1);
        idle_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || irq !== 1'b1) idle_bad++;
            step();
        end
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL drained_idle: bad cycles %0d expected 0", idle_bad); end
        bus_write(32'hC, 4'b0001, 32'd1);
        model_irqen = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b expected 0", irq); end
    endtask

    task automatic test_push_on_pop();
        byte unsigned b;
        bus_write(32'hC, 4'b0001, 32'd0);
        model_en = 1'b0;
        model_div = $urandom_range(1, 3);
        bus_write(32'h8, 4'b0011, model_div);
        for (int i = 0; i < DEPTH; i++) begin
            b = $urandom;
            bus_write(32'h0, 4'b0001, {24'd0, b});
            model_push(b);
        end
        bus_write(32'hC, 4'b0001, 32'd1);
        model_en = 1'b1;
        b = $urandom;
        bus_write(32'h0, 4'b0001, {24'd0, b});
        model_q.push_back(b);
        check_frame(0);
        for (int i = 0; i < DEPTH; i++) check_frame(1);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        int d;
        int bad;
        d = $urandom_range(2, 4);
        bus_write(32'h8, 4'b0011, d);
        bus_write(32'h0, 4'b0001, $urandom);
        bus_write(32'h0, 4'b0001, $urandom);
        repeat (d + 1) step();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        bus_read(32'h4, r);
        checks++;
        if (r !== status_word(0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL post_reset_status: got %h expected %h", r, status_word(0, 1'b0, 1'b0));
        end
        bus_read(32'h8, r);
        checks++;
        if (r !== 32'd868) begin errors++; $display("FAIL post_reset_baud: got %h expected %h", r, 32'd868); end
        bad = 0;
        for (int i = 0; i < 10 * d + 10; i++) begin
            if (tx !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL residual_frame: low cycles %0d expected 0", bad); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_registers();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_push_on_pop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
